dual_port_data_memory: RTL and testbench

Parametrised simple-dual-port data memory for the mini-MIPS datapath: one write port with byte enables and one read port with a configurable read-latency pipeline, valid tagging and out-of-range error reporting. It replaces the fixed 1024×32 single-cycle data store. It serves the MEM stage, where loads need a `rd_valid` qualifier and stores need sub-word (`sb`/`sh`) support.

---
 rtl/dual_port_data_memory_if.sv | 34 +++
 rtl/dual_port_data_memory.sv | 116 +++++++++++
 tb/tb_dual_port_data_memory.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/dual_port_data_memory_if.sv
// dual_port_data_memory_if
//   Bundles the write and read request/response signals of the data memory.
//   master : the MEM stage. It drives the requests and receives the responses.
//   slave  : the memory. It receives the requests and drives the responses.
// Signals
//   wr_en/wr_addr/wr_be/wr_data : write request (word address, byte enables)
//   wr_err                      : pulses when the previous write was out of range
//   rd_en/rd_addr               : read request (word address)
//   rd_data/rd_valid/rd_err     : read response after the read latency
interface dual_port_data_memory_if #(
  parameter int WIDTH = 32
);
  logic               wr_en;
  logic [31:0]        wr_addr;
  logic [WIDTH/8-1:0] wr_be;
  logic [WIDTH-1:0]   wr_data;
  logic               wr_err;

  logic               rd_en;
  logic [31:0]        rd_addr;
  logic [WIDTH-1:0]   rd_data;
  logic               rd_valid;
  logic               rd_err;

  modport master (
    output wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
    input  wr_err, rd_data, rd_valid, rd_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
    output wr_err, rd_data, rd_valid, rd_err
  );
endinterface

// File: rtl/dual_port_data_memory.sv
// dual_port_data_memory
//   Simple-dual-port, word-addressed data memory for the mini-MIPS MEM stage.
//   The write port has byte enables. The read port has a READ_LATENCY-deep
//   pipeline (1..4) that tags each result with valid and out-of-range flags.
// Ports
//   clk : rising-edge clock
//   rst : asynchronous active-high reset. It clears the pipeline and error
//         flags. It does not clear the array.
//   bus : dual_port_data_memory_if.slave (see the interface for the signals)
// Parameters
//   WIDTH        : word width, a multiple of 8
//   DEPTH        : number of words. Must be above 13 because of the legacy
//                  init word.
//   READ_LATENCY : cycles from a read request to rd_valid, 1..4
module dual_port_data_memory #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 1
) (
  input logic                    clk,
  input logic                    rst,
  dual_port_data_memory_if.slave bus
);

  localparam int          NB      = WIDTH / 8;
  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  // Power-up image: all zero, except word 13 = 9. Existing programs expect
  // that value.
  logic [WIDTH-1:0] mem_q [DEPTH] = '{13: WIDTH'(9), default: '0};

  // Read pipeline. Index 0 is the capture stage, and the last index drives
  // the outputs.
  logic [READ_LATENCY-1:0] valid_q;
  logic [READ_LATENCY-1:0] err_q;
  logic [WIDTH-1:0]        data_q [READ_LATENCY];
  logic                    wr_err_q;

  logic                    wr_in_range;
  logic                    rd_in_range;
  logic                    wr_fire;
  logic [AW-1:0]           wr_idx;
  logic [AW-1:0]           rd_idx;
  logic                    wr_err_d;
  logic [WIDTH-1:0]        rd_data_d;
  logic                    rd_err_d;

  // The comparison uses all 32 address bits, so an out-of-range address never
  // aliases onto a real word.
  assign wr_in_range = (bus.wr_addr < DEPTH_W);
  assign rd_in_range = (bus.rd_addr < DEPTH_W);
  assign wr_idx      = bus.wr_addr[AW-1:0];
  assign rd_idx      = bus.rd_addr[AW-1:0];
  assign wr_fire     = bus.wr_en && wr_in_range && !rst;
  // With no enabled byte, a write does nothing. It therefore cannot be in error.
  assign wr_err_d    = bus.wr_en && (bus.wr_be != '0) && !wr_in_range;

  // NOTE: the array has no reset branch. Resetting a memory would force it
  //       into flops, and the contents must survive rst anyway.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int b = 0; b < NB; b++) begin
        if (bus.wr_be[b]) mem_q[wr_idx][8*b +: 8] <= bus.wr_data[8*b +: 8];
      end
    end
  end

  // Snapshot of the array in the request cycle. A same-cycle write to the
  // same word is merged in here (write-first), because the array itself only
  // updates at the edge.
  // NOTE: the outputs get a default first, so every path assigns them and no
  //       latch is inferred. Combinational logic uses blocking '='.
  always_comb begin
    rd_data_d = '0;
    rd_err_d  = 1'b0;
    if (!rd_in_range) begin
      rd_err_d = 1'b1;
    end else begin
      rd_data_d = mem_q[rd_idx];
      if (wr_fire && (bus.wr_addr == bus.rd_addr)) begin
        for (int b = 0; b < NB; b++) begin
          if (bus.wr_be[b]) rd_data_d[8*b +: 8] = bus.wr_data[8*b +: 8];
        end
      end
    end
  end

  // NOTE: state registers use non-blocking '<='. All stages then sample the
  //       values from before the edge, so the shift pipeline works.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_err_q <= 1'b0;
      valid_q  <= '0;
      err_q    <= '0;
      for (int i = 0; i < READ_LATENCY; i++) data_q[i] <= '0;
    end else begin
      wr_err_q   <= wr_err_d;
      valid_q[0] <= bus.rd_en;
      err_q[0]   <= bus.rd_en & rd_err_d;
      // An empty stage keeps its data, so rd_data holds the last result.
      if (bus.rd_en) data_q[0] <= rd_data_d;
      for (int i = 1; i < READ_LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        err_q[i]   <= err_q[i-1];
        if (valid_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign bus.rd_valid = valid_q[READ_LATENCY-1];
  assign bus.rd_err   = err_q[READ_LATENCY-1];
  assign bus.rd_data  = data_q[READ_LATENCY-1];
  assign bus.wr_err   = wr_err_q;

endmodule

// File: tb/tb_dual_port_data_memory.sv
// tb_dual_port_data_memory
//   Directed bench for dual_port_data_memory with DEPTH=1024 and
//   READ_LATENCY=4. Each expected value is worked out by hand from the
//   memory's documented behaviour.
module tb_dual_port_data_memory;

  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  dual_port_data_memory_if #(.WIDTH(32)) bus ();

  dual_port_data_memory #(
    .WIDTH       (32),
    .DEPTH       (1024),
    .READ_LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Step to just after the next rising edge. Inputs are driven there and
  // outputs are sampled there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_be   = '0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    bus.rd_addr = '0;
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] data, input logic exp_err);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_be   = be;
    bus.wr_data = data;
    tick();
    bus.wr_en = 1'b0;
    bus.wr_be = '0;
    check({tag, "_wr_err"}, 32'(bus.wr_err), 32'(exp_err));
  endtask

  // Isolated read. It checks the latency, the result, and that the data holds
  // once rd_valid drops.
  task automatic do_read(input string tag, input logic [31:0] addr,
                         input logic [31:0] exp_data, input logic exp_err);
    bus.rd_en   = 1'b1;
    bus.rd_addr = addr;
    tick();
    bus.rd_en = 1'b0;
    for (int c = 1; c < LAT; c++) begin
      check({tag, "_early_valid"}, 32'(bus.rd_valid), 32'd0);
      tick();
    end
    check({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
    check({tag, "_data"},  bus.rd_data,         exp_data);
    check({tag, "_err"},   32'(bus.rd_err),     32'(exp_err));
    tick();
    check({tag, "_valid_drop"}, 32'(bus.rd_valid), 32'd0);
    check({tag, "_data_hold"},  bus.rd_data,         exp_data);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle();
    tick(); tick(); tick();
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_rd_err",   32'(bus.rd_err),   32'd0);
    check("rst_rd_data",  bus.rd_data,       32'd0);
    check("rst_wr_err",   32'(bus.wr_err),   32'd0);
    rst = 1'b0;
    tick();

    // Power-up image.
    do_read("init13", 32'd13, 32'd9, 1'b0);

    // Basic write then read, with the full latency check.
    do_write("w5", 32'd5, 4'b1111, 32'hDEADBEEF, 1'b0);
    do_read ("r5", 32'd5, 32'hDEADBEEF, 1'b0);

    // Byte enables. Bytes 0 and 2 are replaced.
    do_write("w7a", 32'd7, 4'b1111, 32'h11223344, 1'b0);
    do_write("w7b", 32'd7, 4'b0101, 32'hAABBCCDD, 1'b0);
    do_read ("r7",  32'd7, 32'h11BB33DD, 1'b0);

    // Collision. The read in cycle A comes before the write. The read in
    // cycle B is at the same time as the write to word 9 (be=1100).
    bus.rd_en   = 1'b1;
    bus.rd_addr = 32'd9;
    tick();
    bus.wr_en   = 1'b1;
    bus.wr_addr = 32'd9;
    bus.wr_be   = 4'b1100;
    bus.wr_data = 32'hCAFEF00D;
    tick();
    idle();
    tick(); tick();
    check("col_pre_valid", 32'(bus.rd_valid), 32'd1);
    check("col_pre_data",  bus.rd_data,       32'h0);
    tick();
    check("col_same_valid", 32'(bus.rd_valid), 32'd1);
    check("col_same_data",  bus.rd_data,       32'hCAFE0000);
    tick();
    check("col_after_valid", 32'(bus.rd_valid), 32'd0);
    do_read("r9", 32'd9, 32'hCAFE0000, 1'b0);

    // Range checks. An out-of-range write pulses wr_err for one cycle and
    // does not alias onto low addresses.
    do_write("w1024", 32'd1024, 4'b1111, 32'hFFFFFFFF, 1'b1);
    tick();
    check("wr_err_pulse_end", 32'(bus.wr_err), 32'd0);
    do_write("w1024_be0", 32'd1024, 4'b0000, 32'hFFFFFFFF, 1'b0);
    do_write("w_hi",      32'h0001_0005, 4'b1111, 32'h55555555, 1'b1);
    do_read ("r0_unch",   32'd0, 32'h0, 1'b0);
    do_read ("r5_unch",   32'd5, 32'hDEADBEEF, 1'b0);
    do_read ("r_oob",     32'h400, 32'h0, 1'b1);

    // Back-to-back reads of words 0..7.
    for (int i = 0; i < 8; i++) do_write("wpipe", 32'(i), 4'b1111, 32'h1000 + 32'(i), 1'b0);
    for (int c = 0; c < 8 + LAT; c++) begin
      int e;
      bus.rd_en   = (c < 8);
      bus.rd_addr = 32'(c);
      tick();
      e = c - (LAT - 1);
      if (e >= 0 && e < 8) begin
        check("pipe_valid", 32'(bus.rd_valid), 32'd1);
        check("pipe_data",  bus.rd_data,       32'h1000 + 32'(e));
      end else begin
        check("pipe_idle", 32'(bus.rd_valid), 32'd0);
      end
    end
    idle();

    // Reset in mid-flight. Two reads are issued, then the third request
    // arrives together with a one-cycle rst.
    bus.rd_en   = 1'b1;
    bus.rd_addr = 32'd1;
    tick();
    bus.rd_addr = 32'd2;
    tick();
    bus.rd_addr = 32'd3;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(bus.rd_valid), 32'd0);
    check("mid_rst_data",  bus.rd_data,       32'd0);
    tick();
    rst = 1'b0;
    idle();
    for (int c = 0; c < LAT + 2; c++) begin
      check("mid_rst_no_valid", 32'(bus.rd_valid), 32'd0);
      tick();
    end
    do_read("r2_after_rst", 32'd2, 32'h1002, 1'b0);
    do_read("r7_after_rst", 32'd7, 32'h1007, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
